hex_display_mux: RTL and testbench
==================================

Name: hex_display_mux

Overview:
- Display-side consumer of the 8-bit accumulator value produced by the on-chip arithmetic block.
- Captures the 8-bit value on a rising edge of a load strobe.
- Time-multiplexes the two hex nibbles onto one 7-segment bus plus one digit-select line, so it fits the 8 output pins of a tile.
- Sits between the accumulator output and the tile io_out pins.

Parameters:
- REFRESH_DIV, 1024: clock cycles each digit is shown before switching. Legal range is 2 or more; 1 is illegal and is caught by an elaboration assertion.
- CNT_W, $clog2(REFRESH_DIV): refresh counter width. Derived; not overridden.

Ports:
- clock  input  1  sole clock
- reset_n  input  1  asynchronous, active-low reset
- value  input  8  accumulator value to display
- load  input  1  level input; a rising edge captures value
- blank  input  1  forces all segments off while high
- seg  output  7  segment drive, active high; seg[0]=a ... seg[6]=g
- digit_sel  output  1  0 = low-nibble digit lit, 1 = high-nibble digit lit

Behaviour:
- Interface: one clock (clock). reset_n is asynchronous and active-low. All state is reset asynchronously when reset_n=0.
- Reset values:
  - val_q = 8'h00, load_q = 0, cnt = 0, digit state = DIGIT_LO.
  - seg = 7'h00, digit_sel = 0.
- Load edge detect:
  - load_q registers load every cycle.
  - Capture occurs when load && !load_q; val_q <= value in that cycle.
  - Holding load high captures once only.
  - If load is already high when reset releases, the first clock edge after release captures.
- Refresh counter:
  - cnt counts 0 .. REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle (cnt == REFRESH_DIV-1), the digit state toggles.
- FSM has two states:
  - DIGIT_LO -> DIGIT_HI on wrap.
  - DIGIT_HI -> DIGIT_LO on wrap.
  - No other transitions.
- Output register:
  - seg and digit_sel are both registered and always update together, so there is no ghosting.
  - seg_next = blank ? 7'h00 : hex7(nibble), where nibble = val_q[3:0] in DIGIT_LO and val_q[7:4] in DIGIT_HI.
  - digit_sel_next = (state == DIGIT_HI).
  - Latency is one cycle from a val_q, state or blank change to the outputs.
  - Capture-to-display latency is 2 cycles after the load rising edge.
- hex7 table, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Simultaneous events:
  - A capture and a wrap in the same cycle both take effect.
  - The next output shows the new value's nibble for the new digit.
- blank does not stop cnt or the FSM. Releasing blank resumes the current digit with no phase reset.
- Reset asserted mid-refresh: outputs go to 7'h00 / 0 immediately, without waiting for a clock edge. After release, refresh restarts at DIGIT_LO, cnt = 0.

Optional Feature:
- Macro: HEX_LZ_BLANK_EN
- Defined: leading-zero blanking. In DIGIT_HI, when val_q[7:4] == 4'h0, seg_next = 7'h00. The low digit is always shown, so the value 8'h00 displays as a blank digit plus "0". Timing is unchanged.
- Undefined: the high digit always shows its nibble, including "0" (7'h3F).

Decomposition:
- Package hex_disp_pkg:
  - typedef enum logic {DIGIT_LO, DIGIT_HI} digit_e.
  - localparam SEG_OFF = 7'h00.
  - localparam array HEX7[16] holding the table above.
- Sub-module hex_to_7seg: combinational, 4-bit nibble in, 7-bit seg out, indexes HEX7. Instantiated once, fed by the nibble mux.
- Edge detect, counter, FSM and output register stay in hex_display_mux.

Test Plan:
- Reset: REFRESH_DIV=4; hold reset_n=0 with clocks running -> seg=7'h00, digit_sel=0. Release -> outputs are 7'h3F/0 for 4 cycles, then 7'h3F/1 (7'h00/1 with HEX_LZ_BLANK_EN).
- Capture latency: value=8'hA5, pulse load for 1 cycle -> 2 cycles later seg=7'h6D in DIGIT_LO. After the next wrap plus 1 cycle, seg=7'h77 with digit_sel=1.
- Single capture: hold load high for 10 cycles while value changes from 8'h12 to 8'h34 mid-hold -> display stays on 12 ("2"=5B, "1"=06). Drop load, then raise it again -> display shows 34.
- Blank: blank=1 for 6 cycles spanning a wrap -> seg=7'h00 while digit_sel still toggles on schedule. After blank drops, seg shows the correct nibble one cycle later.
- Collision: load rising edge in the cycle cnt==3 (REFRESH_DIV=4), value 8'hF0, previously 8'h00 -> next output is digit_sel=1, seg=7'h71.
- Async reset mid-operation: assert reset_n=0 between clock edges while the display shows A5 -> seg=7'h00 and digit_sel=0 before the next edge, and val_q reads 8'h00 after release.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and the 7-segment glyph table for the hex display path.
package hex_disp_pkg;

  typedef enum logic {DIGIT_LO = 1'b0, DIGIT_HI = 1'b1} digit_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment order: bit0 = a ... bit6 = g, active high.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment glyph decoder.
module hex_to_7seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7[nibble];
  end

endmodule

// File: rtl/hex_display_mux.sv
// Captures an 8-bit value on a load rising edge and time-multiplexes its two
// hex digits onto one registered 7-segment bus. Option: HEX_LZ_BLANK_EN.
module hex_display_mux
  import hex_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       digit_sel
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("hex_display_mux: REFRESH_DIV must be 2 or more");
  end

  logic [7:0]       val_q;
  logic             load_q;
  logic [CNT_W-1:0] cnt;
  digit_e           state, state_d;
  logic             capture, wrap;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [6:0]       seg_next;

  assign capture = load & ~load_q;
  assign wrap    = (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    if (wrap) begin
      state_d = (state == DIGIT_LO) ? DIGIT_HI : DIGIT_LO;
    end
  end

  always_comb begin
    nibble = (state == DIGIT_HI) ? val_q[7:4] : val_q[3:0];
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    seg_next = glyph;
    if (blank) begin
      seg_next = SEG_OFF;
    end
`ifdef HEX_LZ_BLANK_EN
    else if ((state == DIGIT_HI) && (val_q[7:4] == 4'h0)) begin
      seg_next = SEG_OFF;
    end
`endif
  end

  // seg and digit_sel share one register stage so a digit switch never
  // shows the previous digit's segments.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      val_q     <= '0;
      load_q    <= 1'b0;
      cnt       <= '0;
      state     <= DIGIT_LO;
      seg       <= SEG_OFF;
      digit_sel <= 1'b0;
    end else begin
      load_q    <= load;
      if (capture) begin
        val_q <= value;
      end
      cnt       <= wrap ? '0 : cnt + 1'b1;
      state     <= state_d;
      seg       <= seg_next;
      digit_sel <= (state == DIGIT_HI);
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed, table-driven bench for hex_display_mux with REFRESH_DIV = 4.
module tb_hex_display_mux;

  logic       clock;
  logic       reset_n;
  logic [7:0] value;
  logic       load;
  logic       blank;
  logic [6:0] seg;
  logic       digit_sel;

  int checks = 0;
  int errors = 0;

`ifdef HEX_LZ_BLANK_EN
  localparam logic [6:0] HI0 = 7'h00;
`else
  localparam logic [6:0] HI0 = 7'h3F;
`endif

  typedef struct {
    logic [7:0] value;
    logic       load;
    logic       blank;
    logic [6:0] seg;
    logic       sel;
  } vec_t;

  vec_t vecs[$];

  hex_display_mux #(.REFRESH_DIV(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .value     (value),
    .load      (load),
    .blank     (blank),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [6:0] exp_seg, input logic exp_sel);
    checks++;
    if (seg !== exp_seg || digit_sel !== exp_sel) begin
      errors++;
      $display("FAIL %s: seg=%h digit_sel=%b, expected seg=%h digit_sel=%b",
               name, seg, digit_sel, exp_seg, exp_sel);
    end
  endtask

  task automatic add(input logic [7:0] v, input logic l, input logic b,
                     input logic [6:0] s, input logic d, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      vecs.push_back('{value: v, load: l, blank: b, seg: s, sel: d});
    end
  endtask

  task automatic step(input string name, input logic [6:0] s, input logic d);
    @(posedge clock);
    #1;
    check(name, s, d);
  endtask

  initial begin
    // Post-reset refresh, then capture of A5 in the high-digit phase
    add(8'h00, 1'b0, 1'b0, 7'h3F, 1'b0, 4);
    add(8'h00, 1'b0, 1'b0, HI0,   1'b1, 1);
    add(8'hA5, 1'b1, 1'b0, HI0,   1'b1, 1);
    add(8'hA5, 1'b0, 1'b0, 7'h77, 1'b1, 2);
    add(8'hA5, 1'b0, 1'b0, 7'h6D, 1'b0, 4);
    add(8'hA5, 1'b0, 1'b0, 7'h77, 1'b1, 1);
    // load held 10 cycles, value changes mid-hold: only 12 is captured
    add(8'h12, 1'b1, 1'b0, 7'h77, 1'b1, 1);
    add(8'h12, 1'b1, 1'b0, 7'h06, 1'b1, 1);
    add(8'h34, 1'b1, 1'b0, 7'h06, 1'b1, 1);
    add(8'h34, 1'b1, 1'b0, 7'h5B, 1'b0, 4);
    add(8'h34, 1'b1, 1'b0, 7'h06, 1'b1, 3);
    add(8'h34, 1'b0, 1'b0, 7'h06, 1'b1, 1);
    add(8'h34, 1'b1, 1'b0, 7'h5B, 1'b0, 1);
    add(8'h34, 1'b0, 1'b0, 7'h66, 1'b0, 3);
    add(8'h34, 1'b0, 1'b0, 7'h4F, 1'b1, 1);
    // blank across a wrap: digit_sel keeps toggling
    add(8'h34, 1'b0, 1'b1, 7'h00, 1'b1, 3);
    add(8'h34, 1'b0, 1'b1, 7'h00, 1'b0, 3);
    add(8'h34, 1'b0, 1'b0, 7'h66, 1'b0, 1);
    add(8'h34, 1'b0, 1'b0, 7'h4F, 1'b1, 1);
    // load 00, then capture F0 exactly on the wrap cycle
    add(8'h00, 1'b1, 1'b0, 7'h4F, 1'b1, 1);
    add(8'h00, 1'b0, 1'b0, HI0,   1'b1, 2);
    add(8'h00, 1'b0, 1'b0, 7'h3F, 1'b0, 3);
    add(8'hF0, 1'b1, 1'b0, 7'h3F, 1'b0, 1);
    add(8'hF0, 1'b0, 1'b0, 7'h71, 1'b1, 2);

    reset_n = 1'b0;
    value   = 8'h00;
    load    = 1'b0;
    blank   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hold", 7'h00, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      value = vecs[i].value;
      load  = vecs[i].load;
      blank = vecs[i].blank;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].sel);
    end

    // Async reset between edges while A5 is on display
    value = 8'hA5;
    load  = 1'b1;
    step("ar_load", 7'h71, 1'b1);
    load  = 1'b0;
    step("ar_hi_a", 7'h77, 1'b1);
    step("ar_lo_5", 7'h6D, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_async", 7'h00, 1'b0);
    step("ar_held", 7'h00, 1'b0);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) step($sformatf("ar_lo%0d", n), 7'h3F, 1'b0);
    step("ar_hi_zero", HI0, 1'b1);

    // load already high when reset releases: first edge captures, once only
    reset_n = 1'b0;
    value   = 8'hC3;
    load    = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step("rl_cap", 7'h3F, 1'b0);
    value = 8'h11;
    for (int n = 0; n < 3; n++) step($sformatf("rl_lo%0d", n), 7'h4F, 1'b0);
    step("rl_hi", 7'h39, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
